// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between an instruction-fetch
// port and a data port. One access at a time: grant in IDLE, MEM_LAT cycles
// in BUSY, then a one-cycle rvalid pulse to the port that owned the access.
// Optional feature macro: MEM_ARBITER_RR_EN selects round-robin arbitration;
// when undefined, data has fixed priority with a fetch-starvation override.
module mem_arbiter #(
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        m_w,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata
);

  localparam int unsigned CW = $clog2(MEM_LAT + 1);
`ifndef MEM_ARBITER_RR_EN
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
`endif

  typedef enum logic {ST_IDLE, ST_BUSY} state_e;

  state_e          state_q,    state_d;
  logic [CW-1:0]   cnt_q,      cnt_d;
  logic            owner_q,    owner_d;   // 1 = fetch owns the access
  logic [31:0]     addr_q,     addr_d;
  logic [31:0]     wdata_q,    wdata_d;
  logic            we_q,       we_d;
  logic            i_rvalid_q, i_rvalid_d;
  logic            d_rvalid_q, d_rvalid_d;
  logic [31:0]     i_rdata_q,  i_rdata_d;
  logic [31:0]     d_rdata_q,  d_rdata_d;
`ifdef MEM_ARBITER_RR_EN
  logic            rr_q,       rr_d;      // 1 = data won last
`else
  logic [SW-1:0]   starve_q,   starve_d;
`endif

  logic gnt_i;
  logic gnt_d;
  logic busy;
  logic last_cyc;

  assign busy     = (state_q == ST_BUSY);
  assign last_cyc = busy && (cnt_q == '0);

  // Winner selection; grants only while IDLE, never both at once
  always_comb begin
    gnt_i = 1'b0;
    gnt_d = 1'b0;
    if (state_q == ST_IDLE) begin
`ifdef MEM_ARBITER_RR_EN
      if (i_req && d_req) begin
        gnt_i = rr_q;
        gnt_d = ~rr_q;
      end else begin
        gnt_i = i_req;
        gnt_d = d_req;
      end
`else
      if (i_req && (!d_req || (starve_q == SW'(STARVE_MAX)))) begin
        gnt_i = 1'b1;
      end else begin
        gnt_d = d_req;
      end
`endif
    end
  end

`ifdef MEM_ARBITER_RR_EN
  // Round-robin pointer remembers which port won the last grant
  always_comb begin
    rr_d = rr_q;
    if (gnt_i || gnt_d) begin
      rr_d = gnt_d;
    end
  end
`else
  // Starvation counter: counts lost fetch requests, saturating at STARVE_MAX
  always_comb begin
    starve_d = starve_q;
    if (gnt_i) begin
      starve_d = '0;
    end else if ((state_q == ST_IDLE) && i_req && (starve_q != SW'(STARVE_MAX))) begin
      starve_d = starve_q + SW'(1);
    end
  end
`endif

  // Access sequencing: latch the winner, count down, return the response
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;
    i_rvalid_d = 1'b0;
    d_rvalid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (gnt_i || gnt_d) begin
          state_d = ST_BUSY;
          owner_d = gnt_i;
          addr_d  = gnt_i ? i_addr : d_addr;
          wdata_d = gnt_i ? 32'd0 : d_wdata;
          we_d    = gnt_d & d_we;
          cnt_d   = CW'(MEM_LAT - 1);
        end
      end
      ST_BUSY: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          if (owner_q) begin
            i_rvalid_d = 1'b1;
            i_rdata_d  = m_rdata;
          end else begin
            d_rvalid_d = 1'b1;
            d_rdata_d  = we_q ? 32'd0 : m_rdata;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; reset aborts any access in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      owner_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
`ifdef MEM_ARBITER_RR_EN
      rr_q       <= 1'b0;
`else
      starve_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      i_rvalid_q <= i_rvalid_d;
      d_rvalid_q <= d_rvalid_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
`ifdef MEM_ARBITER_RR_EN
      rr_q       <= rr_d;
`else
      starve_q   <= starve_d;
`endif
    end
  end

  assign i_gnt    = gnt_i;
  assign d_gnt    = gnt_d;
  assign i_rvalid = i_rvalid_q;
  assign d_rvalid = d_rvalid_q;
  assign i_rdata  = i_rdata_q;
  assign d_rdata  = d_rdata_q;

  // Memory side is quiet outside BUSY; write strobe only in the final cycle
  assign m_addr  = busy ? addr_q  : 32'd0;
  assign m_wdata = busy ? wdata_q : 32'd0;
  assign m_w     = last_cyc && we_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares one single-ported `memory` instance between the processor's instruction-fetch port and its data port. It sits between `processor` and a unified memory, so one memory bank holds both program and data. Each access is granted, sequenced for a fixed memory latency, and its response returned with a one-cycle valid pulse. The requester must stall meanwhile.

## Interface
- `MEM_LAT`, 1: memory access cycles per transaction (≥1)
- `STARVE_MAX`, 4: consecutive fetch denials before fetch is forced to win (fixed-priority mode only, ≥1)

- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `i_req`  in  1  fetch request, held until `i_gnt`
- `i_addr`  in  32  fetch address
- `i_gnt`  out  1  fetch request accepted this cycle
- `i_rvalid`  out  1  one-cycle pulse, `i_rdata` valid
- `i_rdata`  out  32  fetched instruction
- `d_req`  in  1  data request, held until `d_gnt`
- `d_we`  in  1  1 = write, 0 = read
- `d_addr`  in  32  data address
- `d_wdata`  in  32  write data
- `d_gnt`  out  1  data request accepted this cycle
- `d_rvalid`  out  1  one-cycle pulse; read data valid, or write done
- `d_rdata`  out  32  read data (0 for writes)
- `m_w`  out  1  memory write enable
- `m_addr`  out  32  memory address
- `m_wdata`  out  32  memory write data
- `m_rdata`  in  32  memory read data (combinational from `m_addr`)

## Operation
- States: IDLE and BUSY. A down-counter `cnt` of width $clog2(MEM_LAT+1) tracks the access.
- IDLE with any request: the arbiter picks a winner and asserts its `*_gnt` combinationally in that cycle. It never asserts both. At the edge it latches owner, addr, wdata and we (we is 0 for fetch), loads `cnt = MEM_LAT-1`, and moves to BUSY.
- BUSY: `m_addr`/`m_wdata` are driven from the latched values. `m_w = we` only in the final BUSY cycle (`cnt == 0`); otherwise 0. The arbiter decrements `cnt` each cycle.
- Final BUSY edge: the arbiter captures `m_rdata` (or 0 for a write) into the owner's `*_rdata`, sets the owner's `*_rvalid` for the next cycle only, and returns to IDLE.
- Outside BUSY: `m_addr`, `m_wdata` and `m_w` are 0.
- `*_rdata` holds its last value until the next response to that port.
- Fixed priority: data wins. `starve` counts IDLE cycles where `i_req` is high and fetch loses. When `starve == STARVE_MAX`, fetch wins and `starve` clears. `starve` also clears on any fetch grant. It saturates and never wraps.
- Requests seen during BUSY are ignored; no grant is issued. Requesters keep `*_req` high.
- Request dropped before grant: no effect.

## Timing
- Grant in cycle T, `m_addr` valid T+1..T+MEM_LAT, `*_rvalid` high in T+MEM_LAT+1.
- The arbiter is IDLE in the `rvalid` cycle and may grant again in it. Peak throughput is one access per MEM_LAT+1 cycles.
- Reset values: all `*_gnt`, `*_rvalid`, `m_w` = 0; `*_rdata`, `m_addr`, `m_wdata` = 0; state IDLE; `cnt`, `starve` and the round-robin pointer = 0.
- Reset asserted mid-access: the arbiter aborts immediately. No `rvalid` and no `m_w` pulse are produced for the aborted access.
- `m_w` is never high on a cycle when `m_addr` is not the latched address.

## Configuration
- `MEM_ARBITER_RR_EN` defined: round-robin arbitration. A 1-bit pointer records the last winner. On contention the other port wins; with a single requester, that requester wins. `starve` and `STARVE_MAX` are unused, and `starve` is held at 0.
- Macro undefined: fixed data priority with the starvation override described above.

## Test plan
- Single fetch, MEM_LAT=1, mem[0]=0x0F0000C1: `i_req`, `i_addr`=0 at T → `i_gnt` at T, `i_rvalid` with `i_rdata`=0x0F0000C1 at T+2, `d_rvalid` stays 0.
- Data write then read, MEM_LAT=3: write addr 8, data 0xDEADBEEF → `m_w` high only at T+3, `d_rvalid` at T+4; the read of addr 8 then returns 0xDEADBEEF.
- Continuous contention, fixed priority, STARVE_MAX=4, MEM_LAT=1: `d_req` and `i_req` held high → four data grants, then one fetch grant, and the pattern repeats.
- Same stimulus with `MEM_ARBITER_RR_EN` → grants alternate data, fetch, data, fetch…; each `rvalid` goes to the matching port.
- Reset pulsed at T+1 of a write with MEM_LAT=2 → `m_w` never asserted, no `d_rvalid`, all outputs 0. A fresh request after reset is granted normally.
- Back-to-back fetches, MEM_LAT=1, `i_req` held → `i_gnt` every 2nd cycle, coincident with the previous `i_rvalid`.
